// File: rtl/ip_pkg.sv
// Shared constants and state encoding for the IPv4 header generator.
package ip_pkg;

   localparam int unsigned IP_HDR_BYTES   = 20;
   localparam logic [7:0]  IP_VER_IHL     = 8'h45;
   localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
   localparam logic [15:0] IP_MAX_PAYLOAD = 16'd65515;

   localparam logic [4:0]  IP_LAST_BYTE   = 5'(IP_HDR_BYTES - 1);
   localparam logic [4:0]  IP_LAST_WORD   = 5'(IP_HDR_BYTES / 2 - 1);

   typedef enum logic [1:0] {IDLE, CSUM, SEND} ip_state_e;

endpackage

// File: rtl/ip_csum16.sv
// 16-bit one's-complement accumulator; the end-around carry is folded in the same cycle
// the word is added, so sum_o is always a folded 16-bit value.
module ip_csum16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic [15:0] word_i,
   output logic [15:0] sum_o
);

   logic [15:0] acc_q, acc_d;
   logic [16:0] raw;

   always_comb begin
      raw   = {1'b0, acc_q} + {1'b0, word_i};
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = raw[15:0] + {15'd0, raw[16]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign sum_o = acc_q;

endmodule

// File: rtl/ip_header_gen.sv
// IPv4 header generator: sums the header in 10 cycles, then streams 20 bytes MSB-first.
// Optional IP_ID_AUTO_EN replaces the ident input with an internal per-packet counter.
module ip_header_gen
   import ip_pkg::*;
#(
   parameter logic [31:0] SRC_IP   = 32'hC0A80132,
   parameter logic [31:0] DST_IP   = 32'hC0A80164,
   parameter logic [7:0]  TTL      = 8'h40,
   parameter logic [7:0]  PROTOCOL = IP_PROTO_UDP,
   parameter logic        DF       = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] payload_len,
   input  logic [15:0] ident,
   output logic        busy,
   output logic        err,
   output logic [7:0]  ip_data,
   output logic        ip_valid,
   input  logic        ip_ready,
   output logic        ip_last,
   output logic        done
);

   ip_state_e   state_q, state_d;
   logic [4:0]  cnt_q, cnt_d, cnt_inc;
   logic [15:0] len_q, len_d, id_q, id_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d, last_q, last_d, busy_q, busy_d;
   logic        err_q, err_d, done_q, done_d;
   logic        csum_clr, csum_en, last_hs;
   logic [15:0] csum_word, csum_sum, csum, next_id;

   function automatic logic [7:0] hdr_byte(input logic [4:0]  idx, input logic [15:0] len,
                                           input logic [15:0] id, input logic [15:0] ck);
      logic [7:0] b;
      case (idx)
         5'd0:    b = IP_VER_IHL;
         5'd1:    b = 8'h00;
         5'd2:    b = len[15:8];
         5'd3:    b = len[7:0];
         5'd4:    b = id[15:8];
         5'd5:    b = id[7:0];
         5'd6:    b = {1'b0, DF, 1'b0, 5'b0};
         5'd7:    b = 8'h00;
         5'd8:    b = TTL;
         5'd9:    b = PROTOCOL;
         5'd10:   b = ck[15:8];
         5'd11:   b = ck[7:0];
         5'd12:   b = SRC_IP[31:24];
         5'd13:   b = SRC_IP[23:16];
         5'd14:   b = SRC_IP[15:8];
         5'd15:   b = SRC_IP[7:0];
         5'd16:   b = DST_IP[31:24];
         5'd17:   b = DST_IP[23:16];
         5'd18:   b = DST_IP[15:8];
         5'd19:   b = DST_IP[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   assign csum    = ~csum_sum;
   assign last_hs = (state_q == SEND) && valid_q && ip_ready && (cnt_q == IP_LAST_BYTE);

`ifdef IP_ID_AUTO_EN
   logic [15:0] id_cnt_q, id_cnt_d;
   logic        unused_ident;

   assign unused_ident = ^ident;
   // Advances on the final handshake so a start taken in the done cycle sees the new value.
   assign id_cnt_d     = last_hs ? id_cnt_q + 16'd1 : id_cnt_q;
   assign next_id      = id_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_cnt_q <= '0;
      end else begin
         id_cnt_q <= id_cnt_d;
      end
   end
`else
   assign next_id = ident;
`endif

   ip_csum16 u_csum (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (csum_clr),
      .en_i   (csum_en),
      .word_i (csum_word),
      .sum_o  (csum_sum)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      id_d      = id_q;
      data_d    = data_q;
      valid_d   = valid_q;
      last_d    = last_q;
      busy_d    = busy_q;
      err_d     = 1'b0;
      done_d    = 1'b0;
      csum_clr  = 1'b0;
      csum_en   = 1'b0;
      cnt_inc   = cnt_q + 5'd1;
      // Checksum field is summed as zero while the header words are accumulated.
      csum_word = {hdr_byte({cnt_q[3:0], 1'b0}, len_q, id_q, 16'h0000),
                   hdr_byte({cnt_q[3:0], 1'b1}, len_q, id_q, 16'h0000)};
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (payload_len > IP_MAX_PAYLOAD) begin
                  err_d = 1'b1;
               end else begin
                  len_d    = payload_len + 16'd20;
                  id_d     = next_id;
                  busy_d   = 1'b1;
                  cnt_d    = '0;
                  csum_clr = 1'b1;
                  state_d  = CSUM;
               end
            end
         end
         CSUM: begin
            csum_en = 1'b1;
            if (cnt_q == IP_LAST_WORD) begin
               cnt_d   = '0;
               data_d  = IP_VER_IHL;
               valid_d = 1'b1;
               state_d = SEND;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         SEND: begin
            if (valid_q && ip_ready) begin
               if (cnt_q == IP_LAST_BYTE) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  data_d  = 8'h00;
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d  = cnt_inc;
                  data_d = hdr_byte(cnt_inc, len_q, id_q, csum);
                  last_d = (cnt_inc == IP_LAST_BYTE);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         id_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         id_q    <= id_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign busy     = busy_q;
   assign err      = err_q;
   assign ip_data  = data_q;
   assign ip_valid = valid_q;
   assign ip_last  = last_q;
   assign done     = done_q;

endmodule

// File: tb/tb_ip_header_gen.sv
// Self-checking bench for ip_header_gen; compares streamed headers with an arithmetic model.
module tb_ip_header_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        ip_ready = 1'b0;
   logic [15:0] payload_len = '0;
   logic [15:0] ident = '0;
   logic        busy, err, ip_valid, ip_last, done;
   logic [7:0]  ip_data;

   int          n_vec = 0;
   int          n_fail = 0;
   logic [7:0]  got[$];
   int          last_at[$];
   int          first_v, n_done, n_err, hold_bad, busy_bad;
   bit          timed_out;
   logic [15:0] id_ctr = '0;

   localparam logic [159:0] BASIC_HDR = 160'h4500002E000040004011B6D8C0A80132C0A80164;

   always #5 clk = ~clk;

   ip_header_gen dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .payload_len (payload_len),
      .ident       (ident),
      .busy        (busy),
      .err         (err),
      .ip_data     (ip_data),
      .ip_valid    (ip_valid),
      .ip_ready    (ip_ready),
      .ip_last     (ip_last),
      .done        (done)
   );

   // Whole-header sum, folded afterwards until it fits in 16 bits.
   function automatic logic [159:0] model_hdr(input logic [15:0] pl, input logic [15:0] id_in);
      logic [15:0]  id;
      logic [159:0] h;
      logic [31:0]  s;
`ifdef IP_ID_AUTO_EN
      id = id_ctr;
`else
      id = id_in;
`endif
      h = {8'h45, 8'h00, pl + 16'd20, id, 16'h4000, 8'h40, 8'h11, 16'h0000,
           32'hC0A80132, 32'hC0A80164};
      s = '0;
      for (int i = 0; i < 10; i++) s += {16'h0000, h[159-16*i -: 16]};
      while (s > 32'h0000FFFF) s = (s & 32'h0000FFFF) + (s >> 16);
      h[79:64] = ~s[15:0];
      return h;
   endfunction

   function automatic logic [159:0] pack_got(input int base);
      logic [159:0] v;
      for (int i = 0; i < 20; i++)
         v[159-8*i -: 8] = (base + i < got.size()) ? got[base+i] : 8'hxx;
      return v;
   endfunction

   // Starts one request and monitors the stream until want_done done pulses or a cycle budget.
   task automatic run_pkt(input logic [15:0] pl, input logic [15:0] id, input int rdy_mode,
                          input bit inject, input bit b2b, input logic [15:0] pl2,
                          input logic [15:0] id2, input int want_done);
      logic       prev_v, prev_r;
      logic [7:0] prev_d;
      int         settle;
      got.delete();
      last_at.delete();
      first_v = -1; n_done = 0; n_err = 0; hold_bad = 0; busy_bad = 0; settle = 0;
      timed_out = 1'b1;
      @(negedge clk);
      start = 1'b1; payload_len = pl; ident = id; ip_ready = (rdy_mode == 0);
      @(posedge clk);
      prev_v = 1'b0; prev_r = 1'b1; prev_d = '0;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (rdy_mode == 0) ip_ready = 1'b1;
         else ip_ready = (k % 7 >= 2 && k % 7 <= 4) ? 1'b0 : 1'($urandom % 2);
         if (inject && (k == 3 || k == 14)) begin
            start = 1'b1; payload_len = 16'd100; ident = 16'hBEEF;
         end
         if (done) begin
            n_done++;
            if (b2b && n_done == 1) begin
               start = 1'b1; payload_len = pl2; ident = id2;
            end
         end
         if (ip_valid && first_v < 0) first_v = k;
         if (prev_v && !prev_r && (!ip_valid || ip_data !== prev_d)) hold_bad++;
         if (ip_valid && !busy) busy_bad++;
         if (err) n_err++;
         if (ip_valid && ip_ready) begin
            got.push_back(ip_data);
            if (ip_last) last_at.push_back(got.size() - 1);
         end
         prev_v = ip_valid; prev_r = ip_ready; prev_d = ip_data;
         if (n_done >= want_done) begin
            settle++;
            if (settle >= 3) begin
               timed_out = 1'b0;
               break;
            end
         end
      end
      id_ctr += 16'(n_done);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #2;
      n_vec++;
      if ({busy, err, ip_valid, ip_last, done, ip_data} !== 13'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 0", {busy, err, ip_valid, ip_last, done, ip_data});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      logic [159:0] exp;
      exp = model_hdr(16'd26, 16'h0000);
      run_pkt(16'd26, 16'h0000, 0, 1'b0, 1'b0, 16'd0, 16'd0, 1);
      n_vec++;
      if (timed_out) begin
         n_fail++;
         $display("FAIL basic_timeout: got %0d done pulses want 1", n_done);
      end
      n_vec++;
      if (got.size() != 20) begin
         n_fail++;
         $display("FAIL basic_count: got %0d bytes want 20", got.size());
      end
      n_vec++;
      if (pack_got(0) !== BASIC_HDR) begin
         n_fail++;
         $display("FAIL basic_literal: got %h want %h", pack_got(0), BASIC_HDR);
      end
      n_vec++;
      if (pack_got(0) !== exp) begin
         n_fail++;
         $display("FAIL basic_model: got %h want %h", pack_got(0), exp);
      end
      n_vec++;
      if (first_v != 11) begin
         n_fail++;
         $display("FAIL basic_latency: got %0d want 11", first_v);
      end
      n_vec++;
      if (last_at.size() != 1 || last_at[0] != 19) begin
         n_fail++;
         $display("FAIL basic_last: got %0d marks (first %0d) want 1 at 19", last_at.size(),
                  (last_at.size() > 0) ? last_at[0] : -1);
      end
      n_vec++;
      if (n_done != 1 || busy_bad != 0 || n_err != 0) begin
         n_fail++;
         $display("FAIL basic_ctrl: got done=%0d busy_bad=%0d err=%0d want 1/0/0",
                  n_done, busy_bad, n_err);
      end
      n_vec++;
      if ({busy, ip_valid, ip_last, done} !== 4'b0000) begin
         n_fail++;
         $display("FAIL basic_idle: got %b want 0000", {busy, ip_valid, ip_last, done});
      end
   endtask

   task automatic test_zero_len;
      logic [159:0] exp;
      exp = model_hdr(16'd0, 16'h0000);
      run_pkt(16'd0, 16'h0000, 0, 1'b0, 1'b0, 16'd0, 16'd0, 1);
      n_vec++;
      if (pack_got(0) !== exp) begin
         n_fail++;
         $display("FAIL zero_len_model: got %h want %h", pack_got(0), exp);
      end
`ifndef IP_ID_AUTO_EN
      n_vec++;
      if (pack_got(0) !== 160'h45000014000040004011B6F2C0A80132C0A80164) begin
         n_fail++;
         $display("FAIL zero_len_literal: got %h want B6F2 header", pack_got(0));
      end
`endif
   endtask

   task automatic test_backpressure;
      logic [159:0] exp;
      exp = model_hdr(16'd26, 16'h0000);
      run_pkt(16'd26, 16'h0000, 1, 1'b0, 1'b0, 16'd0, 16'd0, 1);
      n_vec++;
      if (got.size() != 20 || pack_got(0) !== exp) begin
         n_fail++;
         $display("FAIL backpressure_bytes: got %0d bytes %h want 20 bytes %h",
                  got.size(), pack_got(0), exp);
      end
      n_vec++;
      if (hold_bad != 0 || n_done != 1 || timed_out) begin
         n_fail++;
         $display("FAIL backpressure_hold: got hold_bad=%0d done=%0d want 0/1", hold_bad, n_done);
      end
   endtask

   task automatic test_overflow;
      logic [159:0] exp;
      int           seen, errs;
      @(negedge clk);
      start = 1'b1; payload_len = 16'd65516; ident = 16'h1234; ip_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n_vec++;
      if ({err, busy, ip_valid} !== 3'b100) begin
         n_fail++;
         $display("FAIL overflow_err: got err/busy/valid=%b want 100", {err, busy, ip_valid});
      end
      seen = 0; errs = 0;
      repeat (15) begin
         @(negedge clk);
         if (ip_valid || busy) seen++;
         if (err) errs++;
      end
      n_vec++;
      if (seen != 0 || errs != 0) begin
         n_fail++;
         $display("FAIL overflow_quiet: got active=%0d extra_err=%0d want 0/0", seen, errs);
      end
      exp = model_hdr(16'd26, 16'h0777);
      run_pkt(16'd26, 16'h0777, 0, 1'b0, 1'b0, 16'd0, 16'd0, 1);
      n_vec++;
      if (pack_got(0) !== exp) begin
         n_fail++;
         $display("FAIL overflow_after: got %h want %h", pack_got(0), exp);
      end
   endtask

   task automatic test_ignore_start;
      logic [159:0] exp;
      exp = model_hdr(16'd300, 16'hA5A5);
      run_pkt(16'd300, 16'hA5A5, 0, 1'b1, 1'b0, 16'd0, 16'd0, 1);
      n_vec++;
      if (got.size() != 20 || pack_got(0) !== exp) begin
         n_fail++;
         $display("FAIL ignore_bytes: got %0d bytes %h want 20 bytes %h",
                  got.size(), pack_got(0), exp);
      end
      n_vec++;
      if (n_done != 1 || {busy, ip_valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL ignore_single: got done=%0d busy/valid=%b want 1/00",
                  n_done, {busy, ip_valid});
      end
   endtask

   task automatic test_back_to_back;
      logic [159:0] exp1, exp2;
      exp1 = model_hdr(16'd40, 16'h1111);
      id_ctr++;
      exp2 = model_hdr(16'd1000, 16'h2222);
      id_ctr--;
      run_pkt(16'd40, 16'h1111, 0, 1'b0, 1'b1, 16'd1000, 16'h2222, 2);
      n_vec++;
      if (got.size() != 40 || n_done != 2) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d bytes %0d dones want 40/2", got.size(), n_done);
      end
      n_vec++;
      if (pack_got(0) !== exp1) begin
         n_fail++;
         $display("FAIL b2b_first: got %h want %h", pack_got(0), exp1);
      end
      n_vec++;
      if (pack_got(20) !== exp2) begin
         n_fail++;
         $display("FAIL b2b_second: got %h want %h", pack_got(20), exp2);
      end
      n_vec++;
      if (last_at.size() != 2 || last_at[0] != 19 || last_at[1] != 39) begin
         n_fail++;
         $display("FAIL b2b_last: got %0d last marks want 2 at 19/39", last_at.size());
      end
   endtask

   task automatic test_mid_reset;
      int seen;
      @(negedge clk);
      start = 1'b1; payload_len = 16'd500; ident = 16'h0BAD; ip_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (17) @(negedge clk);
      n_vec++;
      if (ip_valid !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_precond: got valid/busy=%b want 11", {ip_valid, busy});
      end
      #1 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({busy, err, ip_valid, ip_last, done, ip_data} !== 13'd0) begin
         n_fail++;
         $display("FAIL midrst_async: got %b want 0", {busy, err, ip_valid, ip_last, done, ip_data});
      end
      id_ctr = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (ip_valid || busy || done) seen++;
      end
      n_vec++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL midrst_resume: got %0d active cycles want 0", seen);
      end
      run_pkt(16'd26, 16'h0000, 0, 1'b0, 1'b0, 16'd0, 16'd0, 1);
      n_vec++;
      if (got.size() != 20 || pack_got(0) !== BASIC_HDR) begin
         n_fail++;
         $display("FAIL midrst_fresh: got %h want %h", pack_got(0), BASIC_HDR);
      end
   endtask

   task automatic test_random;
      logic [159:0] exp;
      logic [15:0]  pl, id;
      for (int n = 0; n < 6; n++) begin
         pl  = (n == 0) ? 16'd65515 : 16'($urandom_range(0, 65515));
         id  = 16'($urandom);
         exp = model_hdr(pl, id);
         run_pkt(pl, id, n % 2, 1'b0, 1'b0, 16'd0, 16'd0, 1);
         n_vec++;
         if (got.size() != 20 || pack_got(0) !== exp || hold_bad != 0) begin
            n_fail++;
            $display("FAIL random_%0d: got %0d bytes %h hold_bad=%0d want 20 bytes %h",
                     n, got.size(), pack_got(0), hold_bad, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_backpressure();
      test_overflow();
      test_ignore_start();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/ip_header_gen.md
Name: ip_header_gen

Overview:
Parametrised IPv4 header generator for the Ethernet TX path. It accepts a per-packet request carrying payload length and identification. It computes Total Length and a real header checksum, then streams the 20 header bytes MSB-first over a valid/ready byte interface. Its output feeds the frame assembler after the MAC header and ahead of the UDP header.

Parameters:
SRC_IP, 32'hC0A80132, source address (192.168.1.50)
DST_IP, 32'hC0A80164, destination address (192.168.1.100)
TTL, 8'h40, time-to-live byte
PROTOCOL, 8'h11, protocol byte (UDP)
DF, 1'b1, Don't-Fragment flag; fragment offset always 0

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only in IDLE
payload_len  in  16  IP payload bytes (UDP header + data)
ident  in  16  Identification field
busy  out  1  high from accepted start until last byte handshake
err  out  1  one-cycle pulse: request rejected (length overflow)
ip_data  out  8  header byte
ip_valid  out  1  ip_data valid
ip_ready  in  1  downstream accept
ip_last  out  1  high with byte 19
done  out  1  one-cycle pulse after byte 19 handshake

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, err, ip_valid, ip_last, done = 0; ip_data = 8'h00; accumulator cleared.
- Clock and reset are as decided: one clock, clk; reset rst_n, asynchronous, active-low.
- IDLE: on start=1, latch payload_len and ident.
  - If payload_len > 16'd65515: pulse err next cycle, stay IDLE, no output, busy stays 0.
  - Otherwise: total_len = payload_len + 20, busy=1, go CSUM.
- start while busy is ignored; latched fields do not change.
- CSUM: 10 cycles, one header word per cycle (words 0..9, checksum word = 0).
  - 17-bit accumulator with end-around carry folded in the same cycle.
  - On exit, csum = ~acc[15:0]; go SEND.
- SEND: ip_valid rises exactly 11 cycles after the cycle start was sampled.
  - Byte order: 45, 00 (TOS), len_hi, len_lo, id_hi, id_lo, {0,DF,0,5'b0}, 00, TTL, PROTOCOL, csum_hi, csum_lo, SRC_IP[31:24]..[7:0], DST_IP[31:24]..[7:0].
  - A byte advances only on ip_valid & ip_ready.
  - ip_data and ip_valid are held stable while ip_ready=0. No combinational ready-to-valid path.
  - ip_last=1 only with byte 19.
  - On the byte-19 handshake: ip_valid=0, ip_last=0, busy=0, done pulses next cycle, go IDLE.
  - A new start is accepted in the cycle done is high.
- Byte counter: 5 bits, never exceeds 19.
- rst_n asserted mid-CSUM or mid-SEND aborts immediately to reset values. No partial resume.

Optional Feature:
IP_ID_AUTO_EN
- Defined: ident input is ignored. An internal 16-bit counter supplies Identification.
  - The counter resets to 0 and increments by 1 (wrapping FFFF->0000) on each done.
  - Rejected (err) requests do not increment it.
- Not defined: Identification = ident latched at start. No counter is present.

Decomposition:
- Package ip_pkg:
  - IP_HDR_BYTES=20, IP_VER_IHL=8'h45, IP_PROTO_UDP=8'h11, IP_MAX_PAYLOAD=16'd65515.
  - State enum {IDLE, CSUM, SEND}.
- Sub-module ip_csum16: clear/enable/16-bit word in; 16-bit folded one's-complement sum out. Reusable later for UDP checksum.

Test Plan:
- Default params, payload_len=26, ident=0, ip_ready=1 -> 20 bytes 45 00 00 2E 00 00 40 00 40 11 B6 D8 C0 A8 01 32 C0 A8 01 64. ip_valid rises 11 cycles after start; ip_last with 0x64; done once.
- payload_len=0, ident=0 -> total length 00 14, checksum B6 F2.
- Same as first, ip_ready toggled pseudo-randomly (≥3 consecutive low cycles) -> identical byte sequence, data held stable while not ready, no byte dropped or duplicated.
- payload_len=16'd65516 -> err pulse 1 cycle, busy=0, ip_valid never asserts. Then payload_len=26 -> normal packet.
- start pulsed during CSUM and SEND -> ignored, single packet out. start in done cycle -> second packet back-to-back, checksum recomputed.
- rst_n low at byte 7 of SEND -> all outputs 0 asynchronously. After release, a fresh start yields a full correct 20-byte header. With IP_ID_AUTO_EN, three packets carry ident 0000, 0001, 0002, with checksums adjusted accordingly.
